// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control path: sequencer state encoding,
// legal parameter ranges and the per-stage write-enable bundle.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LU_STALL = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_HALT     = 3'd3,
        ST_ERR      = 3'd4
    } ctrl_state_e;

    localparam int LU_BUBBLES_MIN = 1;
    localparam int LU_BUBBLES_MAX = 3;
    localparam int MAX_WAIT_MIN   = 1;
    localparam int MAX_WAIT_MAX   = 255;

    // Wide enough to count up to MAX_WAIT_MAX consecutive busy cycles.
    localparam int WAIT_W = 8;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic back;
    } stage_en_t;

    localparam stage_en_t EN_ALL   = '{pc: 1'b1, ifid: 1'b1, back: 1'b1};
    localparam stage_en_t EN_NONE  = '{pc: 1'b0, ifid: 1'b0, back: 1'b0};
    localparam stage_en_t EN_DRAIN = '{pc: 1'b0, ifid: 1'b0, back: 1'b1};

    function automatic logic in_range(input int val, input int lo, input int hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr restarts the count and, together
// with inc, lets the current cycle be counted as the first one.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF-ID-RR-EX-MEM-WB pipeline: owns load-use
// bubbles, memory freezes with timeout, halt/resume and a stall statistic.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES = 1,
    parameter int MAX_WAIT   = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_i,
    input  logic             mem_busy_i,
    input  logic             branch_taken_i,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             back_we,
    output logic [2:0]       state_o,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    if (!in_range(LU_BUBBLES, LU_BUBBLES_MIN, LU_BUBBLES_MAX)) begin : g_bad_lu_bubbles
        $error("pipe_hazard_ctrl: LU_BUBBLES out of range");
    end
    if (!in_range(MAX_WAIT, MAX_WAIT_MIN, MAX_WAIT_MAX)) begin : g_bad_max_wait
        $error("pipe_hazard_ctrl: MAX_WAIT out of range");
    end

    localparam logic [1:0]        BUB_RELOAD = 2'(LU_BUBBLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);

    ctrl_state_e       state;
    ctrl_state_e       next_state;
    ctrl_state_e       saved_state;
    ctrl_state_e       eff_state;
    logic [1:0]        bub_cnt;
    logic [1:0]        bub_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_clr;
    logic              wait_inc;
    logic              save_en;
    logic              err_set;
    stage_en_t         en;
    logic              bubble;
    logic              flush;

    // A released memory wait behaves exactly like the state it interrupted,
    // including that state's transition, in the same cycle.
    always_comb begin
        eff_state  = state;
        next_state = state;
        bub_next   = bub_cnt;
        en         = EN_NONE;
        bubble     = 1'b0;
        flush      = 1'b0;
        save_en    = 1'b0;
        wait_clr   = 1'b0;
        wait_inc   = 1'b0;
        err_set    = 1'b0;

        if ((state == ST_MEM_WAIT) && !mem_busy_i) begin
            eff_state = saved_state;
        end

        case (eff_state)
            ST_RUN, ST_LU_STALL: begin
                if (mem_busy_i) begin
                    save_en  = 1'b1;
                    wait_clr = 1'b1;
                    wait_inc = 1'b1;
                    if (MAX_WAIT == 1) begin
                        next_state = ST_ERR;
                        err_set    = 1'b1;
                    end else begin
                        next_state = ST_MEM_WAIT;
                    end
                end else if (branch_taken_i) begin
                    en         = EN_ALL;
                    flush      = 1'b1;
                    next_state = ST_RUN;
                end else if (eff_state == ST_LU_STALL) begin
                    en     = EN_DRAIN;
                    bubble = 1'b1;
                    if (bub_cnt <= 2'd1) begin
                        next_state = ST_RUN;
                    end else begin
                        bub_next   = bub_cnt - 2'd1;
                        next_state = ST_LU_STALL;
                    end
                end else if (halt_i) begin
                    en         = EN_DRAIN;
                    bubble     = 1'b1;
                    next_state = ST_HALT;
                end else if (load_use_i) begin
                    en     = EN_DRAIN;
                    bubble = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        bub_next   = BUB_RELOAD;
                        next_state = ST_LU_STALL;
                    end else begin
                        next_state = ST_RUN;
                    end
                end else begin
                    en         = EN_ALL;
                    next_state = ST_RUN;
                end
            end

            // Only reached while memory is still busy; everything stays frozen.
            ST_MEM_WAIT: begin
                wait_inc = 1'b1;
                if (wait_cnt >= WAIT_LAST) begin
                    next_state = ST_ERR;
                    err_set    = 1'b1;
                end
            end

            ST_HALT: begin
                en     = EN_DRAIN;
                bubble = 1'b1;
                if (resume_i) begin
                    next_state = ST_RUN;
                end
            end

            default: begin
                next_state = ST_ERR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            saved_state <= ST_RUN;
            bub_cnt     <= 2'd0;
            timeout_err <= 1'b0;
        end else begin
            state   <= next_state;
            bub_cnt <= bub_next;
            if (save_en) begin
                saved_state <= eff_state;
            end
            if (err_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .count (wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (!en.pc),
        .count (stall_cnt)
    );

    // Enables are forced low for the whole time reset is asserted.
    assign pc_we       = rst_n & en.pc;
    assign ifid_we     = rst_n & en.ifid;
    assign back_we     = rst_n & en.back;
    assign idex_bubble = rst_n & bubble;
    assign ifid_flush  = rst_n & flush;
    assign idex_flush  = rst_n & flush;
    assign state_o     = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (LU_BUBBLES=2 / CNT_W=16
// and LU_BUBBLES=3 / CNT_W=4) share stimulus; each step names the one it checks.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n        = 1'b1;
    logic load_use     = 1'b0;
    logic mem_busy     = 1'b0;
    logic branch_taken = 1'b0;
    logic halt         = 1'b0;
    logic resume       = 1'b0;

    logic        a_pc_we, a_ifid_we, a_idex_bubble, a_ifid_flush, a_idex_flush, a_back_we, a_timeout_err;
    logic [2:0]  a_state;
    logic [15:0] a_stall_cnt;
    logic        b_pc_we, b_ifid_we, b_idex_bubble, b_ifid_flush, b_idex_flush, b_back_we, b_timeout_err;
    logic [2:0]  b_state;
    logic [3:0]  b_stall_cnt;

    pipe_hazard_ctrl #(.LU_BUBBLES(2), .MAX_WAIT(15), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_use_i(load_use), .mem_busy_i(mem_busy),
        .branch_taken_i(branch_taken), .halt_i(halt), .resume_i(resume),
        .pc_we(a_pc_we), .ifid_we(a_ifid_we), .idex_bubble(a_idex_bubble),
        .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .back_we(a_back_we),
        .state_o(a_state), .timeout_err(a_timeout_err), .stall_cnt(a_stall_cnt)
    );

    pipe_hazard_ctrl #(.LU_BUBBLES(3), .MAX_WAIT(15), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_use_i(load_use), .mem_busy_i(mem_busy),
        .branch_taken_i(branch_taken), .halt_i(halt), .resume_i(resume),
        .pc_we(b_pc_we), .ifid_we(b_ifid_we), .idex_bubble(b_idex_bubble),
        .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .back_we(b_back_we),
        .state_o(b_state), .timeout_err(b_timeout_err), .stall_cnt(b_stall_cnt)
    );

    logic [8:0] obs_a, obs_b;
    assign obs_a = {a_state, a_pc_we, a_ifid_we, a_idex_bubble, a_ifid_flush, a_idex_flush, a_back_we};
    assign obs_b = {b_state, b_pc_we, b_ifid_we, b_idex_bubble, b_ifid_flush, b_idex_flush, b_back_we};

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];
    int         sel_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packed as {state[2:0], pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, back_we}
    function automatic logic [8:0] mk(input logic [2:0] st, input logic pc, input logic ifid,
                                      input logic bub, input logic ifl, input logic idfl,
                                      input logic back);
        return {st, pc, ifid, bub, ifl, idfl, back};
    endfunction

    function automatic logic [8:0] f_run();
        return mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction
    function automatic logic [8:0] f_bub(input logic [2:0] st);
        return mk(st, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endfunction
    function automatic logic [8:0] f_frz(input logic [2:0] st);
        return mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [8:0] f_br(input logic [2:0] st);
        return mk(st, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    endfunction

    task automatic compare_out();
        logic [8:0] exp;
        string      tag;
        int         sel;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            sel = sel_q.pop_front();
            check_eq(tag, (sel == 0) ? 32'(obs_a) : 32'(obs_b), 32'(exp));
        end
    endtask

    // Drive one cycle of inputs, record the expected outputs, sample mid-cycle.
    task automatic step(input string tag, input int sel, input logic lu, input logic mb,
                        input logic br, input logic h, input logic r, input logic [8:0] exp);
        @(posedge clk);
        #1;
        load_use     = lu;
        mem_busy     = mb;
        branch_taken = br;
        halt         = h;
        resume       = r;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        @(negedge clk);
        compare_out();
    endtask

    // Inputs are left as they were while reset is applied, so gating is exercised.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check_eq({tag, "_a_outs"}, 32'(obs_a), 32'd0);
        check_eq({tag, "_a_cnt"}, 32'(a_stall_cnt), 32'd0);
        check_eq({tag, "_a_err"}, 32'(a_timeout_err), 32'd0);
        check_eq({tag, "_b_outs"}, 32'(obs_b), 32'd0);
        check_eq({tag, "_b_cnt"}, 32'(b_stall_cnt), 32'd0);
        check_eq({tag, "_b_err"}, 32'(b_timeout_err), 32'd0);
        @(posedge clk);
        #1;
        load_use     = 1'b0;
        mem_busy     = 1'b0;
        branch_taken = 1'b0;
        halt         = 1'b0;
        resume       = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Load-use, two bubbles
        do_reset("rst0");
        step("a_first_run", 0, 0, 0, 0, 0, 0, f_run());
        step("a_lu_det",    0, 1, 0, 0, 0, 0, f_bub(3'd0));
        step("a_lu_stall",  0, 0, 0, 0, 0, 0, f_bub(3'd1));
        step("a_lu_done",   0, 0, 0, 0, 0, 0, f_run());
        check_eq("a_lu_stall_cnt", 32'(a_stall_cnt), 32'd2);

        // Branch beats load-use; branch aborts LU_STALL; priority ordering
        do_reset("rst1");
        step("a_br_over_lu", 0, 1, 0, 1, 0, 0, f_br(3'd0));
        step("a_br_after",   0, 0, 0, 0, 0, 0, f_run());
        check_eq("a_br_stall_cnt", 32'(a_stall_cnt), 32'd0);
        step("b_lu_det",     1, 1, 0, 0, 0, 0, f_bub(3'd0));
        step("b_br_abort",   1, 0, 0, 1, 0, 0, f_br(3'd1));
        step("b_br_run",     1, 0, 0, 0, 0, 0, f_run());
        step("b_mb_over_br", 1, 0, 1, 1, 0, 0, f_frz(3'd0));
        step("b_mb_release", 1, 0, 0, 0, 0, 0, mk(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        step("b_mb_run",     1, 0, 0, 0, 0, 0, f_run());
        step("b_halt_lu",    1, 1, 0, 0, 1, 0, f_bub(3'd0));
        step("b_resume",     1, 0, 0, 0, 0, 1, f_bub(3'd3));
        step("b_resume_run", 1, 0, 0, 0, 0, 0, f_run());

        // Memory wait inside LU_STALL with three bubbles
        do_reset("rst2");
        step("b_lu3_det", 1, 1, 0, 0, 0, 0, f_bub(3'd0));
        step("b_lu3_mb1", 1, 0, 1, 0, 0, 0, f_frz(3'd1));
        for (int i = 2; i <= 4; i++) begin
            step($sformatf("b_lu3_mb%0d", i), 1, 0, 1, 0, 0, 0, f_frz(3'd2));
        end
        step("b_lu3_resume", 1, 0, 0, 0, 0, 0, f_bub(3'd2));
        step("b_lu3_last",   1, 0, 0, 0, 0, 0, f_bub(3'd1));
        step("b_lu3_run",    1, 0, 0, 0, 0, 0, f_run());
        check_eq("b_lu3_stall_cnt", 32'(b_stall_cnt), 32'd7);

        // Memory timeout into ERR
        do_reset("rst3");
        for (int i = 1; i <= 15; i++) begin
            step($sformatf("b_to_busy%0d", i), 1, 0, 1, 0, 0, 0, (i == 1) ? f_frz(3'd0) : f_frz(3'd2));
        end
        check_eq("b_to_err_before", 32'(b_timeout_err), 32'd0);
        for (int i = 16; i <= 20; i++) begin
            step($sformatf("b_to_err%0d", i), 1, 0, 1, 0, 0, 0, f_frz(3'd4));
        end
        check_eq("b_to_err_set", 32'(b_timeout_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("b_err_hold%0d", i), 1, 1, 0, 1, 0, 1, f_frz(3'd4));
        end
        check_eq("b_err_sticky", 32'(b_timeout_err), 32'd1);
        check_eq("b_err_cnt_sat", 32'(b_stall_cnt), 32'd15);

        // Halt, ignored events while halted, resume
        do_reset("rst4");
        step("a_halt_req", 0, 0, 0, 0, 1, 0, f_bub(3'd0));
        for (int i = 0; i < 10; i++) begin
            step($sformatf("a_halted%0d", i), 0, 0, (i == 3), (i == 5), 0, 0, f_bub(3'd3));
        end
        step("a_resume",     0, 0, 0, 0, 0, 1, f_bub(3'd3));
        step("a_resume_run", 0, 0, 0, 0, 0, 0, f_run());
        check_eq("a_halt_stall_cnt", 32'(a_stall_cnt), 32'd12);

        // Reset during a wait that interrupted LU_STALL, then counter saturation
        do_reset("rst5");
        step("b_rw_lu",  1, 1, 0, 0, 0, 0, f_bub(3'd0));
        step("b_rw_mb1", 1, 0, 1, 0, 0, 0, f_frz(3'd1));
        step("b_rw_mb2", 1, 0, 1, 0, 0, 0, f_frz(3'd2));
        do_reset("rst_midwait");
        step("b_rw_after", 1, 0, 0, 0, 0, 0, f_run());
        for (int i = 0; i < 20; i++) begin
            step($sformatf("b_sat_lu%0d", i), 1, 1, 0, 0, 0, 0, f_bub((i % 3 == 0) ? 3'd0 : 3'd1));
            if (i == 10) begin
                check_eq("b_sat_cnt_mid", 32'(b_stall_cnt), 32'd10);
            end
        end
        step("b_sat_tail", 1, 0, 0, 0, 0, 0, f_bub(3'd1));
        step("b_sat_run",  1, 0, 0, 0, 0, 0, f_run());
        check_eq("b_sat_cnt_hold", 32'(b_stall_cnt), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 6-stage pipeline (IF, ID, RR, EX, MEM, WB). It takes the combinational load-use stall from the hazard detector, data-memory busy, EX-stage branch resolution and halt/resume requests. From these it drives the PC and pipeline-register write enables, bubble injection and flushes. It replaces ad-hoc stall wiring with one FSM that owns multi-cycle stalls, memory wait timeouts and a stall statistics counter.

## Interface
- LU_BUBBLES, 1: bubbles inserted per load-use hazard (legal 1..3).
- MAX_WAIT, 15: max consecutive mem_busy cycles before error (legal 1..255).
- CNT_W, 16: stall statistics counter width.

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- load_use_i  in  1  load-use hazard from hazard detector (same cycle).
- mem_busy_i  in  1  data memory not ready; whole pipeline must freeze.
- branch_taken_i  in  1  branch/jump resolved taken in EX.
- halt_i  in  1  halt request (level).
- resume_i  in  1  leave HALT (pulse or level).
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- idex_bubble  out  1  load NOP into ID/RR (control zeroed).
- ifid_flush  out  1  clear IF/ID.
- idex_flush  out  1  clear ID/RR.
- back_we  out  1  write enable for RR/EX, EX/MEM, MEM/WB.
- state_o  out  3  current FSM state.
- timeout_err  out  1  sticky memory timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_we=0, saturating.

## Operation
- States: RUN=0, LU_STALL=1, MEM_WAIT=2, HALT=3, ERR=4. Reset -> RUN.
- Outputs are combinational in state and inputs; state, counters and saved state are registered.
- Default (RUN, no events): pc_we=ifid_we=back_we=1, bubble=flush=0.
- Priority per cycle: mem_busy_i > branch_taken_i > halt_i > load_use_i.
- mem_busy_i=1 in RUN or LU_STALL: all enables, bubble and flush = 0; save return state, freeze bubble counter, wait_cnt=1, go MEM_WAIT.
- MEM_WAIT with busy=1: outputs all 0, wait_cnt++.
  - If wait_cnt==MAX_WAIT and busy is still 1 -> ERR, timeout_err=1.
- MEM_WAIT with busy=0: outputs as the saved state would drive that cycle. The transition from that state happens in the same cycle.
- branch_taken_i (RUN or LU_STALL): pc_we=1, ifid_flush=idex_flush=1, ifid_we=1, back_we=1. Branch aborts LU_STALL -> RUN.
- load_use_i in RUN: pc_we=ifid_we=0, idex_bubble=1, back_we=1.
  - If LU_BUBBLES>1: bub_cnt=LU_BUBBLES-1, go LU_STALL.
- LU_STALL: same outputs as the load-use response. load_use_i is ignored. Decrement bub_cnt; at bub_cnt==1 -> RUN.
- halt_i in RUN: pc_we=ifid_we=0, idex_bubble=1, back_we=1; go HALT. Older instructions drain.
- HALT: same outputs as the halt response. resume_i=1 -> RUN; outputs are HALT values in that cycle. mem_busy_i and branch_taken_i are ignored.
- ERR: all enables 0, bubble/flush 0. Exit only by reset.
- stall_cnt increments every cycle pc_we=0 while rst_n=1. It holds at 2^CNT_W-1.

## Timing
- Zero-cycle response: stall, flush and freeze outputs reflect inputs in the same cycle. No added pipeline latency.
- Load-use: exactly LU_BUBBLES consecutive cycles with pc_we=0, counted from the detection cycle, absent higher-priority events.
- MEM_WAIT cycles are not counted as bubbles. The LU bubble count resumes after the wait.
- Timeout: ERR is entered on the edge ending the MAX_WAIT-th consecutive busy cycle.
- While rst_n=0, all outputs are 0: state_o=0, timeout_err=0, stall_cnt=0, pc_we=ifid_we=back_we=0.
- Reset mid-stall or mid-wait drops all saved state.
- First cycle after reset release: RUN defaults.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum and its 3-bit encoding;
  - the LU_BUBBLES and MAX_WAIT legal ranges;
  - a stage-enable struct {pc, ifid, back}, reused by the forwarding unit and the top level.
- Sub-module sat_counter (parameter W; inc, clr; saturating) is used for stall_cnt and wait_cnt.

## Test plan
- Load-use with LU_BUBBLES=2: load_use_i=1 for one cycle.
  - Expected: pc_we=0 for exactly 2 cycles, idex_bubble=1 for both, state 0->1->0.
- Branch over load-use: load_use_i=1 and branch_taken_i=1 in the same cycle.
  - Expected: pc_we=1, both flushes=1, no LU_STALL entry.
- Memory wait inside LU_STALL (LU_BUBBLES=3): mem_busy_i high 4 cycles at bubble 2.
  - Expected: all enables 0 for 4 cycles, then 2 more bubble cycles, stall_cnt=7.
- Timeout with MAX_WAIT=15: mem_busy_i held 20 cycles.
  - Expected: ERR (state 4) after 15 cycles and timeout_err=1.
  - After busy drops, outputs stay 0 until reset.
- Halt/resume: halt_i pulse, 10 idle cycles, then resume_i.
  - Expected: back_we=1 and pc_we=0 throughout HALT, then RUN defaults the cycle after resume.
- Reset mid-stall and saturation (CNT_W=4): assert rst_n=0 during MEM_WAIT; then run 20 load-use bubbles.
  - Expected: reset gives all outputs 0 and state RUN.
  - Counter sticks at 15.
